fetch_decode_skid_reg: RTL

- Parametrised successor to the single-register IF→ID latch, placed between the fetch stage and the decoder.
- Replaces the plain stall/jump latch with a two-entry skid buffer and a valid/ready handshake on both sides, so the upstream ready is a function of registered state only.
- Adds a prioritised flush that presents a canonical NOP bubble, plus saturating stall and flush performance counters.
- Generalised in PC/instruction width, bubble encoding and counter width.

---
 rtl/fetch_decode_skid_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_decode_skid_reg.sv
// fetch_decode_skid_reg
//   Two-entry skid buffer between fetch and decode. Valid/ready handshake on
//   both sides. up_ready depends only on registered state and rst, so it has
//   no combinational path from dn_ready. flush empties the buffer and takes
//   priority over any handshake. rst overrides flush. Saturating counters
//   track stall cycles and flush cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     discard all buffered entries
//   up_valid/up_pc/up_inst    fetch side entry, up_ready accept
//   dn_valid/dn_pc/dn_inst    decode side entry (pc=0 / NOP when invalid)
//   dn_ready                  decode consumes the presented entry
//   stall_cnt, flush_cnt      saturating performance counters
module fetch_decode_skid_reg #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   input  logic [PC_W-1:0]   up_pc,
   input  logic [INST_W-1:0] up_inst,
   output logic              up_ready,
   output logic              dn_valid,
   output logic [PC_W-1:0]   dn_pc,
   output logic [INST_W-1:0] dn_inst,
   input  logic              dn_ready,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   localparam entry_t           CLR     = '{pc: '0, inst: NOP_INST};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   entry_t m, s;
   entry_t up_e;
   logic   up_fire, dn_fire;

   assign up_e     = '{pc: up_pc, inst: up_inst};
   assign up_ready = !rst && (state != FULL);
   assign dn_valid = (state != EMPTY);
   assign up_fire  = up_valid && up_ready;
   assign dn_fire  = dn_valid && dn_ready;

   // Forced bubble on the outputs whenever nothing valid is held.
   assign dn_pc    = dn_valid ? m.pc   : '0;
   assign dn_inst  = dn_valid ? m.inst : NOP_INST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         m         <= CLR;
         s         <= CLR;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // Stall is sampled on the pre-update state, so a stall in a flush
         // cycle still counts.
         if (dn_valid && !dn_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;

         if (flush) begin
            state <= EMPTY;
            m     <= CLR;
            s     <= CLR;
         end else begin
            case (state)
               EMPTY: begin
                  if (up_fire) begin
                     state <= ONE;
                     m     <= up_e;
                  end
               end
               ONE: begin
                  if (up_fire && dn_fire) begin
                     m <= up_e;
                  end else if (up_fire) begin
                     state <= FULL;
                     s     <= up_e;
                  end else if (dn_fire) begin
                     state <= EMPTY;
                     m     <= CLR;
                  end
               end
               FULL: begin
                  // up_ready is low here, so only the drain can happen.
                  if (dn_fire) begin
                     state <= ONE;
                     m     <= s;
                     s     <= CLR;
                  end
               end
               default: begin
                  state <= EMPTY;
                  m     <= CLR;
                  s     <= CLR;
               end
            endcase
         end
      end
   end

endmodule
